// File: rtl/tournament_predictor_pkg.sv
// Shared definitions for the tournament predictor: 2-bit counter encodings,
// default widths and the saturating counter helpers.
package tournament_predictor_pkg;

    localparam int PC_WIDTH_DEF      = 32;
    localparam int HIST_WIDTH_DEF    = 8;
    localparam int LHT_IDX_WIDTH_DEF = 6;
    localparam int LHIST_WIDTH_DEF   = 8;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_SNT   = 2'd0;
    localparam ctr_t CTR_WNT   = 2'd1;
    localparam ctr_t CTR_WT    = 2'd2;
    localparam ctr_t CTR_ST    = 2'd3;
    localparam ctr_t CTR_RESET = CTR_WNT;

    function automatic ctr_t sat_inc(input ctr_t c);
        return (c == CTR_ST) ? CTR_ST : ctr_t'(c + 2'd1);
    endfunction

    function automatic ctr_t sat_dec(input ctr_t c);
        return (c == CTR_SNT) ? CTR_SNT : ctr_t'(c - 2'd1);
    endfunction

    function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
        return taken ? sat_inc(c) : sat_dec(c);
    endfunction

    function automatic logic ctr_taken(input ctr_t c);
        return (c >= CTR_WT);
    endfunction

endpackage

// File: rtl/tournament_predictor_pht.sv
// Table of 2-bit saturating counters: one combinational read port and one
// synchronous train port; every entry resets to weakly-not-taken.
module pht_2bit
    import tournament_predictor_pkg::*;
#(
    parameter int IDX_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst,
    input  logic [IDX_WIDTH-1:0] rd_idx_i,
    output logic [1:0]           rd_ctr_o,
    input  logic                 upd_valid_i,
    input  logic [IDX_WIDTH-1:0] upd_idx_i,
    input  logic                 upd_taken_i
);

    localparam int DEPTH = 1 << IDX_WIDTH;

    ctr_t ctr_q [DEPTH];
    ctr_t ctr_d;

    assign ctr_d    = ctr_next(ctr_q[upd_idx_i], upd_taken_i);
    assign rd_ctr_o = ctr_q[rd_idx_i];

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctr_q[i] <= CTR_RESET;
            end
        end else if (upd_valid_i) begin
            ctr_q[upd_idx_i] <= ctr_d;
        end
    end

endmodule

// File: rtl/tournament_predictor.sv
// Fetch-stage tournament predictor: gshare + local-history components picked
// by a per-PC chooser, with a speculative GHR repaired on mispredict.
module tournament_predictor
    import tournament_predictor_pkg::*;
#(
    parameter int PC_WIDTH      = PC_WIDTH_DEF,
    parameter int HIST_WIDTH    = HIST_WIDTH_DEF,
    parameter int LHT_IDX_WIDTH = LHT_IDX_WIDTH_DEF,
    parameter int LHIST_WIDTH   = LHIST_WIDTH_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst,
    input  logic [PC_WIDTH-1:0]   F_PC_i,
    input  logic                  F_is_branch_i,
    input  logic                  F_stall_i,
    output logic                  F_predict_o,
    output logic                  F_global_predict_o,
    output logic                  F_local_predict_o,
    output logic [HIST_WIDTH-1:0] F_global_history_o,
    input  logic                  E_train_vaild_i,
    input  logic [PC_WIDTH-1:0]   E_train_PC_i,
    input  logic                  E_train_taken_i,
    input  logic                  E_train_predict_i,
    input  logic                  E_train_global_predict_i,
    input  logic                  E_train_local_predict_i,
    input  logic [HIST_WIDTH-1:0] E_train_global_history_i
);

    localparam int LHT_DEPTH = 1 << LHT_IDX_WIDTH;

    logic [HIST_WIDTH-1:0]    ghr_q, ghr_d;
    logic [LHIST_WIDTH-1:0]   lht_q [LHT_DEPTH];
    logic [LHIST_WIDTH-1:0]   lht_d;

    logic [HIST_WIDTH-1:0]    f_cidx, f_gidx, e_cidx, e_gidx;
    logic [LHT_IDX_WIDTH-1:0] f_lidx, e_lidx;
    logic [LHIST_WIDTH-1:0]   f_lhist, e_lhist;
    logic [1:0]               g_ctr, l_ctr, c_ctr;
    logic                     mispredict;
    logic                     chooser_train;

    // PC bits outside the index fields do not take part in prediction.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{F_PC_i[PC_WIDTH-1:HIST_WIDTH+2], F_PC_i[1:0],
                              E_train_PC_i[PC_WIDTH-1:HIST_WIDTH+2], E_train_PC_i[1:0]};

    assign f_cidx  = F_PC_i[HIST_WIDTH+1:2];
    assign f_gidx  = f_cidx ^ ghr_q;
    assign f_lidx  = F_PC_i[LHT_IDX_WIDTH+1:2];
    assign f_lhist = lht_q[f_lidx];

    assign e_cidx  = E_train_PC_i[HIST_WIDTH+1:2];
    assign e_gidx  = e_cidx ^ E_train_global_history_i;
    assign e_lidx  = E_train_PC_i[LHT_IDX_WIDTH+1:2];
    assign e_lhist = lht_q[e_lidx];
    assign lht_d   = {e_lhist[LHIST_WIDTH-2:0], E_train_taken_i};

    // Training has no backpressure: a valid resolved branch is consumed on
    // the edge it is presented, and same-cycle reads see pre-update tables.
    assign mispredict    = E_train_vaild_i & (E_train_taken_i != E_train_predict_i);
    assign chooser_train = E_train_vaild_i & (E_train_global_predict_i != E_train_local_predict_i);

    pht_2bit #(.IDX_WIDTH(HIST_WIDTH)) u_gpht (
        .clk_i       (clk_i),
        .rst         (rst),
        .rd_idx_i    (f_gidx),
        .rd_ctr_o    (g_ctr),
        .upd_valid_i (E_train_vaild_i),
        .upd_idx_i   (e_gidx),
        .upd_taken_i (E_train_taken_i)
    );

    pht_2bit #(.IDX_WIDTH(LHIST_WIDTH)) u_lpht (
        .clk_i       (clk_i),
        .rst         (rst),
        .rd_idx_i    (f_lhist),
        .rd_ctr_o    (l_ctr),
        .upd_valid_i (E_train_vaild_i),
        .upd_idx_i   (e_lhist),
        .upd_taken_i (E_train_taken_i)
    );

    // Chooser counts toward "global" when the global component was right.
    pht_2bit #(.IDX_WIDTH(HIST_WIDTH)) u_chooser (
        .clk_i       (clk_i),
        .rst         (rst),
        .rd_idx_i    (f_cidx),
        .rd_ctr_o    (c_ctr),
        .upd_valid_i (chooser_train),
        .upd_idx_i   (e_cidx),
        .upd_taken_i (E_train_global_predict_i == E_train_taken_i)
    );

    assign F_global_predict_o = ctr_taken(g_ctr);
    assign F_local_predict_o  = ctr_taken(l_ctr);
    assign F_predict_o        = ctr_taken(c_ctr) ? F_global_predict_o : F_local_predict_o;
    assign F_global_history_o = ghr_q;

    // A mispredict means the current fetch is on the wrong path, so its shift is dropped.
    always_comb begin
        ghr_d = ghr_q;
        if (mispredict) begin
            ghr_d = {E_train_global_history_i[HIST_WIDTH-2:0], E_train_taken_i};
        end else if (F_is_branch_i && !F_stall_i) begin
            ghr_d = {ghr_q[HIST_WIDTH-2:0], F_predict_o};
        end
    end

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LHT_DEPTH; i++) begin
                lht_q[i] <= '0;
            end
        end else if (E_train_vaild_i) begin
            lht_q[e_lidx] <= lht_d;
        end
    end

endmodule
